// File: rtl/fetch_ifid_pkg.sv
// Shared types and constants for the fetch stage and IF/ID register.
package fetch_ifid_pkg;

    localparam int unsigned XLEN    = 16;
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 11;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [XLEN-1:0]  NOP_INSTR_DEF = 16'h0800;
    localparam logic [OPC_W-1:0] HALT_OP_DEF   = 5'b00000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    // 16-bit ripple-carry adder; carry out is dropped so the PC wraps.
    function automatic logic [XLEN-1:0] rca16(input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] sum;
        logic            c;
        c   = 1'b0;
        sum = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return sum;
    endfunction

endpackage

// File: rtl/fetch_ifid_skid.sv
// One-entry skid buffer holding a returned instruction while decode is stalled.
module fetch_ifid_skid
    import fetch_ifid_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_inc_i,
    output logic            full_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_inc_o
);

    logic            full_q,   full_d;
    logic [XLEN-1:0] instr_q,  instr_d;
    logic [XLEN-1:0] pc_inc_q, pc_inc_d;

    always_comb begin
        full_d   = full_q;
        instr_d  = instr_q;
        pc_inc_d = pc_inc_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d   = 1'b1;
            instr_d  = instr_i;
            pc_inc_d = pc_inc_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q   <= 1'b0;
            instr_q  <= '0;
            pc_inc_q <= '0;
        end else begin
            full_q   <= full_d;
            instr_q  <= instr_d;
            pc_inc_q <= pc_inc_d;
        end
    end

    assign full_o   = full_q;
    assign instr_o  = instr_q;
    assign pc_inc_o = pc_inc_q;

endmodule

// File: rtl/fetch_ifid.sv
// Instruction fetch with a stall-capable memory handshake and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush performance counters.
module fetch_ifid
    import fetch_ifid_pkg::*;
#(
    parameter logic [XLEN-1:0]  RESET_PC  = 16'h0000,
    parameter logic [XLEN-1:0]  NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [OPC_W-1:0] HALT_OP   = HALT_OP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        imem_stall,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instruct,
    output logic [15:0] PCInc,
    output logic        ifid_valid,
    output logic        fetch_halted,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt,
`endif
    output logic        err
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            rd_q, rd_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcinc_q, pcinc_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;
    logic            drop_q, drop_d;

    logic            skid_load, skid_drain, skid_clear, skid_full;
    logic [XLEN-1:0] skid_instr, skid_pcinc;
    logic            full_next;
    logic [XLEN-1:0] pc_plus2;
    logic            hit, wait_done, ret, pending, loaded;
    logic [XLEN-1:0] loaded_instr;
    logic            drop_rst;

    assign pc_plus2  = rca16(pc_q, XLEN'(2));
    assign hit       = (state_q == FETCH) && rd_q && imem_done && !imem_stall;
    assign wait_done = (state_q == WAIT) && imem_done;
    assign ret       = (hit || wait_done) && !drop_q && !redirect;
    assign pending   = ((state_q == WAIT) && !imem_done)
                    || ((state_q == FETCH) && rd_q && imem_stall && !imem_done);
    // A request abandoned by reset must not have its late data accepted.
    assign drop_rst  = (state_q == WAIT) || (drop_q && imem_stall && !imem_done);

    fetch_ifid_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .drain_i  (skid_drain),
        .clear_i  (skid_clear),
        .instr_i  (imem_data),
        .pc_inc_i (pc_plus2),
        .full_o   (skid_full),
        .instr_o  (skid_instr),
        .pc_inc_o (skid_pcinc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pcinc_d      = pcinc_q;
        valid_d      = valid_q;
        drop_d       = drop_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;
        loaded       = 1'b0;
        loaded_instr = skid_full ? skid_instr : imem_data;
        err_d        = err_q | (imem_done && ((state_q == HALT)
                                || ((state_q == FETCH) && !rd_q && !drop_q)));

        if (drop_q && (imem_done || ((state_q != WAIT) && !imem_stall))) begin
            drop_d = 1'b0;
        end

        case (state_q)
            FETCH:   if (rd_q && imem_stall && !imem_done) state_d = WAIT;
            WAIT:    if (imem_done) state_d = FETCH;
            default: state_d = state_q;
        endcase

        if (redirect) begin
            instr_d    = NOP_INSTR;
            pcinc_d    = '0;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            pc_d       = redirect_pc;
            state_d    = pending ? WAIT : FETCH;
            if (pending) drop_d = 1'b1;
        end else begin
            if (ret) pc_d = pc_plus2;
            if (!stall_id) begin
                // Buffered word is older than anything returning now.
                if (skid_full) begin
                    instr_d    = skid_instr;
                    pcinc_d    = skid_pcinc;
                    valid_d    = 1'b1;
                    skid_drain = 1'b1;
                    skid_load  = ret;
                    loaded     = 1'b1;
                end else if (ret) begin
                    instr_d = imem_data;
                    pcinc_d = pc_plus2;
                    valid_d = 1'b1;
                    loaded  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end else if (ret) begin
                skid_load = 1'b1;
            end
            if (loaded && (opcode_of(loaded_instr) == HALT_OP)) state_d = HALT;
        end

        full_next = !skid_clear && (skid_load || (skid_full && !skid_drain));
        rd_d      = (state_d == FETCH) && !full_next && !drop_d;
        halted_d  = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            rd_q     <= !drop_rst;
            instr_q  <= NOP_INSTR;
            pcinc_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            drop_q   <= drop_rst;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_q     <= rd_d;
            instr_q  <= instr_d;
            pcinc_q  <= pcinc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (((state_q == WAIT) || (stall_id && skid_full)) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (redirect && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

    assign imem_rd      = rd_q;
    assign imem_addr    = pc_q;
    assign instruct     = instr_q;
    assign PCInc        = pcinc_q;
    assign ifid_valid   = valid_q;
    assign fetch_halted = halted_q;
    assign err          = err_q;

endmodule
